// File: rtl/interp_sequencer_pkg.sv
// Shared types and constants for the HEVC 8-wide subpixel interpolation sequencer.
package interp_pkg;

  localparam int NUM_PIXEL = 8;
  localparam int TAPS      = 8;
  localparam int FIR_LAT   = 2;
  localparam int ROWS_IN   = NUM_PIXEL + TAPS - 1;
  localparam int INT_TAP   = 3;

  localparam logic [1:0] FRAC_INT = 2'd0;
  localparam logic [1:0] FRAC_A   = 2'd1;
  localparam logic [1:0] FRAC_B   = 2'd2;
  localparam logic [1:0] FRAC_C   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HPASS,
    VPASS,
    DONE
  } state_e;

endpackage

// File: rtl/interp_sequencer_issue_drain_ctr.sv
// Issues indices 0..n-1, then waits LAT drain cycles; also replays each issue LAT cycles later.
module issue_drain_ctr
  import interp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int LAT   = FIR_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] n_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output logic             dly_valid_o,
  output logic [IDX_W-1:0] dly_idx_o
);

  localparam int CNT_W = IDX_W + 1;

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             issue_q, issue_d;
  logic             last_q, last_d;
  logic [LAT-1:0]   pv_q;
  logic [IDX_W-1:0] pi_q [LAT];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    n_d      = n_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      n_d      = n_i;
      active_d = 1'b1;
      cnt_d    = '0;
    end else if (active_q) begin
      if (last_q) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    issue_d = active_d && (cnt_d < {1'b0, n_d});
    last_d  = active_d && (cnt_d == ({1'b0, n_d} + CNT_W'(LAT - 1)));
    idx_d   = issue_d ? cnt_d[IDX_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      n_q      <= '0;
      idx_q    <= '0;
      issue_q  <= 1'b0;
      last_q   <= 1'b0;
      pv_q     <= '0;
      // NOTE: the index pipeline is only LAT deep, so it is reset like any flop; dly_idx_o must read 0 after reset.
      for (int i = 0; i < LAT; i++) pi_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so each stage samples its predecessor's pre-edge value.
      active_q <= active_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      issue_q  <= issue_d;
      last_q   <= last_d;
      pv_q[0]  <= issue_q;
      pi_q[0]  <= idx_q;
      for (int i = 1; i < LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
    end
  end

  assign idx_o       = idx_q;
  assign last_o      = last_q;
  assign dly_valid_o = pv_q[LAT-1];
  assign dly_idx_o   = pi_q[LAT-1];

endmodule

// File: rtl/interp_sequencer.sv
// FSM controller for the 8-wide HEVC interpolation datapath (FILL, HPASS, VPASS, DONE).
// Optional INTERP_SEQ_PERF_EN adds cycle and stall counters for the last block.
module interp_sequencer
  import interp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  frac_x,
  input  logic [1:0]  frac_y,
  input  logic        row_valid,
  output logic        row_ready,
  output logic        load_in,
  output logic [3:0]  row_sel,
  output logic        v_src_sel,
  output logic [1:0]  filt_sel,
  output logic        h_load,
  output logic        out_load,
  output logic [2:0]  out_row,
  output logic        busy,
  output logic        done
`ifdef INTERP_SEQ_PERF_EN
  ,
  output logic [15:0] cyc_cnt,
  output logic [15:0] stall_cnt
`endif
);

  state_e     state_q;
  logic [1:0] fx_q, fy_q, filt_q;
  logic [3:0] fill_cnt_q;
  logic       row_ready_q, v_src_q, busy_q, done_q;
  logic       h_cap_q, h_out_q, v_out_q;

  logic       go_h, fill_last, ctr_start, ctr_last, ctr_dly_valid, h_win;
  logic [3:0] ctr_n, ctr_idx, ctr_dly_idx;

  assign load_in = row_valid & row_ready_q;

  always_comb begin
    go_h      = (fx_q != FRAC_INT) || (fy_q == FRAC_INT);
    fill_last = (state_q == FILL) && load_in && (fill_cnt_q == 4'(ROWS_IN - 1));
    ctr_start = fill_last || ((state_q == HPASS) && ctr_last && (fy_q != FRAC_INT));
    ctr_n     = (fill_last && go_h) ? 4'(ROWS_IN) : 4'(NUM_PIXEL);
  end

  issue_drain_ctr #(.IDX_W(4), .LAT(FIR_LAT)) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .start_i     (ctr_start),
    .n_i         (ctr_n),
    .idx_o       (ctr_idx),
    .last_o      (ctr_last),
    .dly_valid_o (ctr_dly_valid),
    .dly_idx_o   (ctr_dly_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fx_q        <= FRAC_INT;
      fy_q        <= FRAC_INT;
      filt_q      <= FRAC_INT;
      fill_cnt_q  <= '0;
      row_ready_q <= 1'b0;
      v_src_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      h_cap_q     <= 1'b0;
      h_out_q     <= 1'b0;
      v_out_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          fx_q        <= frac_x;
          fy_q        <= frac_y;
          fill_cnt_q  <= '0;
          row_ready_q <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= FILL;
        end
        FILL: if (load_in) begin
          fill_cnt_q <= fill_cnt_q + 4'd1;
          if (fill_last) begin
            fill_cnt_q  <= '0;
            row_ready_q <= 1'b0;
            v_src_q     <= 1'b0;
            if (go_h) begin
              state_q <= HPASS;
              filt_q  <= fx_q;
              h_cap_q <= (fy_q != FRAC_INT);
              h_out_q <= (fy_q == FRAC_INT);
            end else begin
              state_q <= VPASS;
              filt_q  <= fy_q;
              v_out_q <= 1'b1;
            end
          end
        end
        HPASS: if (ctr_last) begin
          h_cap_q <= 1'b0;
          h_out_q <= 1'b0;
          if (fy_q != FRAC_INT) begin
            state_q <= VPASS;
            filt_q  <= fy_q;
            v_src_q <= (fx_q != FRAC_INT);
            v_out_q <= 1'b1;
          end else begin
            state_q <= DONE;
            filt_q  <= FRAC_INT;
            done_q  <= 1'b1;
          end
        end
        VPASS: if (ctr_last) begin
          state_q <= DONE;
          filt_q  <= FRAC_INT;
          v_src_q <= 1'b0;
          v_out_q <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Capture/filler strobes decode only registered pass flags and the counter's delayed issue.
  assign h_win     = (ctr_dly_idx >= 4'(INT_TAP)) && (ctr_dly_idx < 4'(INT_TAP + NUM_PIXEL));
  assign h_load    = h_cap_q & ctr_dly_valid;
  assign out_load  = ctr_dly_valid & (v_out_q | (h_out_q & h_win));
  assign out_row   = !out_load ? 3'd0 :
                     v_out_q   ? ctr_dly_idx[2:0] : 3'(ctr_dly_idx - 4'(INT_TAP));
  assign row_ready = row_ready_q;
  assign row_sel   = ctr_idx;
  assign v_src_sel = v_src_q;
  assign filt_sel  = filt_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef INTERP_SEQ_PERF_EN
  logic [15:0] run_q, stall_run_q, cyc_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= '0;
      stall_run_q <= '0;
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        run_q       <= 16'd1;
        stall_run_q <= '0;
      end else if (state_q != IDLE) begin
        run_q <= run_q + 16'd1;
      end
      if (state_q == FILL && !row_valid) stall_run_q <= stall_run_q + 16'd1;
      if (state_q == DONE) begin
        cyc_cnt_q   <= run_q + 16'd1;
        stall_cnt_q <= stall_run_q;
      end
    end
  end

  assign cyc_cnt   = cyc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_interp_sequencer.sv
// Scoreboard bench for interp_sequencer: stimulus pushes expected strobes, a monitor pops and compares.
module tb_interp_sequencer;
  import interp_pkg::*;

  localparam int EV_H = 0, EV_OUT = 1, EV_DONE = 2, EV_NONE = 3;

  logic       clk = 1'b0;
  logic       rst, start, row_valid;
  logic [1:0] frac_x, frac_y, filt_sel;
  logic       row_ready, load_in, v_src_sel, h_load, out_load, busy, done;
  logic [3:0] row_sel;
  logic [2:0] out_row;
`ifdef INTERP_SEQ_PERF_EN
  logic [15:0] cyc_cnt, stall_cnt;
`endif

  interp_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frac_x    (frac_x),
    .frac_y    (frac_y),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .load_in   (load_in),
    .row_sel   (row_sel),
    .v_src_sel (v_src_sel),
    .filt_sel  (filt_sel),
    .h_load    (h_load),
    .out_load  (out_load),
    .out_row   (out_row),
    .busy      (busy),
    .done      (done)
`ifdef INTERP_SEQ_PERF_EN
    ,
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int row;
    int filt;
    int vsrc;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {16'd0, row_ready, load_in, row_sel, v_src_sel, filt_sel,
            h_load, out_load, out_row, busy, done};
  endfunction

  // Monitor: every strobe the DUT raises must match the head of the scoreboard.
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (h_load || out_load || done) begin
      if (h_load && out_load) check("h_out_exclusive", 32'd1, 32'd0);
      kind = done ? EV_DONE : (h_load ? EV_H : EV_OUT);
      if (sb.size() == 0) begin
        check("unexpected_strobe", kind, EV_NONE);
      end else begin
        e = sb.pop_front();
        check("ev_kind", kind, e.kind);
        check("ev_cycle", cyc, e.cyc);
        if (kind == EV_OUT) check("out_row", out_row, e.row);
        if (kind != EV_DONE) begin
          check("filt_sel", filt_sel, e.filt);
          check("v_src_sel", v_src_sel, e.vsrc);
        end
      end
    end
  end

  task automatic push_ev(input int kind, input int s, input int off, input int row,
                         input int filt, input int vsrc, input int rst_at);
    ev_t e;
    if (rst_at < 0 || off <= rst_at) begin
      e.kind = kind; e.cyc = s + off; e.row = row; e.filt = filt; e.vsrc = vsrc;
      sb.push_back(e);
    end
  endtask

  // One block; offsets k are cycles after the start cycle (k=0).
  task automatic run_block(input int fx, input int fy, input int stall_at, input int stall_len,
                           input int poke_h, input bit poke_done, input int rst_at);
    int  s, p, vp, d, last_k, rs, eb;
    bit  goh, hasv;
    goh  = (fx != 0) || (fy == 0);
    hasv = (fy != 0);
    p    = 16 + stall_len;
    vp   = goh ? p + 17 : p;
    d    = hasv ? vp + 10 : vp;
    s    = cyc;
    if (goh)
      for (int i = 0; i < 15; i++) begin
        if (hasv) push_ev(EV_H, s, p + 2 + i, 0, fx, 0, rst_at);
        else if (i >= 3 && i <= 10) push_ev(EV_OUT, s, p + 2 + i, i - 3, fx, 0, rst_at);
      end
    if (hasv)
      for (int j = 0; j < 8; j++) push_ev(EV_OUT, s, vp + 2 + j, j, fy, (fx != 0) ? 1 : 0, rst_at);
    if (rst_at < 0) push_ev(EV_DONE, s, d, 0, 0, 0, rst_at);
    last_k = (rst_at >= 0) ? rst_at + 2 : d + 3;
    for (int k = 0; k <= last_k; k++) begin
      rst       = (k == rst_at);
      start     = (k == 0) || (k == poke_h) || (poke_done && k == d) || (k == rst_at);
      frac_x    = (k == 0) ? 2'(fx) : 2'(3 - fx);
      frac_y    = (k == 0) ? 2'(fy) : 2'(3 - fy);
      row_valid = !(k >= stall_at && k < stall_at + stall_len);
      @(negedge clk);
      rs = 0;
      if (goh && k >= p && k < p + 15) rs = k - p;
      if (hasv && k >= vp && k < vp + 8) rs = k - vp;
      eb = (k >= 1 && k <= d) ? 1 : 0;
      if (rst_at >= 0 && k > rst_at) begin
        rs = 0;
        eb = 0;
      end
      check("row_sel", row_sel, rs);
      check("busy", busy, eb);
      if (k == 1) check("row_ready_after_start", row_ready, 1);
      if (rst_at >= 0 && k == rst_at + 1) check("outputs_after_rst", all_outs(), 0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    start     = 1'b0;
    row_valid = 1'b1;
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; frac_x = 2'd0; frac_y = 2'd0; row_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    row_valid = 1'b1;
    @(posedge clk);
    #1;

    run_block(2, 1, -1, 0, -1, 1'b0, -1);
`ifdef INTERP_SEQ_PERF_EN
    check("cyc_cnt_2_1", cyc_cnt, 44);
    check("stall_cnt_2_1", stall_cnt, 0);
`endif
    run_block(3, 0, -1, 0, 20, 1'b1, -1);
`ifdef INTERP_SEQ_PERF_EN
    check("cyc_cnt_3_0", cyc_cnt, 34);
`endif
    run_block(0, 1, -1, 0, -1, 1'b0, -1);
`ifdef INTERP_SEQ_PERF_EN
    check("cyc_cnt_0_1", cyc_cnt, 27);
`endif
    run_block(2, 1, 3, 5, -1, 1'b0, -1);
`ifdef INTERP_SEQ_PERF_EN
    check("cyc_cnt_stall", cyc_cnt, 49);
    check("stall_cnt_stall", stall_cnt, 5);
`endif
    run_block(2, 2, -1, 0, -1, 1'b0, 30);
`ifdef INTERP_SEQ_PERF_EN
    check("cyc_cnt_rst", cyc_cnt, 0);
    check("stall_cnt_rst", stall_cnt, 0);
`endif
    run_block(1, 3, -1, 0, -1, 1'b0, -1);
    run_block(0, 0, -1, 0, -1, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
